lut_table_loader: RTL and testbench

- Upstream feeder for the serially loaded LUT stage.
- Accepts random-access entry writes into a staging table, then on command streams the whole table MSB-first as a serial bit plus active-low chip select.
- The downstream serial-to-parallel LUT register captures the stream on the same clock and ends holding the staged table exactly.
- Staging is kept after a commit, so the same table can be re-committed.

---
 rtl/lut_pkg.sv | 19 +
 rtl/lut_stage_table.sv | 32 +++
 rtl/lut_table_loader.sv | 121 ++++++++++++
 tb/tb_lut_table_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lut_pkg.sv
// Shared definitions for the serial LUT table loader: default widths,
// streamed-table size derivation and the loader FSM state type.
package lut_pkg;

    localparam int IN_WIDTH_DEF  = 4;
    localparam int OUT_WIDTH_DEF = 4;

    // Total number of bits in a table of 2**in_width entries of out_width bits.
    function automatic int table_bits(input int in_width, input int out_width);
        return (2 ** in_width) * out_width;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/lut_stage_table.sv
// Staging register file for the LUT loader: one random-access write port,
// whole table presented flat with entry i at [(i+1)*OUT_WIDTH-1 -: OUT_WIDTH].
module lut_stage_table
    import lut_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        wr_en,
    input  logic [IN_WIDTH-1:0]                         wr_addr,
    input  logic [OUT_WIDTH-1:0]                        wr_data,
    output logic [table_bits(IN_WIDTH, OUT_WIDTH)-1:0]  entries
);

    localparam int unsigned ENTRIES = 2 ** IN_WIDTH;

    // Write the addressed entry; table cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (wr_addr == IN_WIDTH'(i)) begin
                    entries[i*OUT_WIDTH +: OUT_WIDTH] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/lut_table_loader.sv
// Staging table plus MSB-first serial commit stream (sd / sd_cs_n) feeding
// the downstream serially loaded LUT register.
// Optional checksum output enabled by `define LUT_TABLE_LOADER_CHECKSUM_EN.
module lut_table_loader
    import lut_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [IN_WIDTH-1:0]  wr_addr,
    input  logic [OUT_WIDTH-1:0] wr_data,
    input  logic                 go,
    output logic                 sd,
    output logic                 sd_cs_n,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_err
`ifdef LUT_TABLE_LOADER_CHECKSUM_EN
    ,
    output logic [OUT_WIDTH-1:0] csum
`endif
);

    localparam int TABLE_BITS = table_bits(IN_WIDTH, OUT_WIDTH);
    localparam int CNT_W      = $clog2(TABLE_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TABLE_BITS - 1);

    state_t                  state;
    logic [TABLE_BITS-1:0]   staging;
    logic [TABLE_BITS-1:0]   shifter;
    logic [CNT_W-1:0]        count;
    logic                    stage_we;

    // Staging only accepts writes in IDLE, and go takes priority over a write.
    always_comb begin
        stage_we = wr_en && (state == IDLE) && !go;
    end

    lut_stage_table #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (stage_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .entries (staging)
    );

    // Loader FSM: snapshot on go, stream MSB-first, one-cycle DONE.
    // The first bit is issued on the accepting edge, so the shifter holds the
    // snapshot already shifted by one and count tracks the bit just issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shifter <= '0;
            count   <= '0;
            sd      <= 1'b0;
            sd_cs_n <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_err  <= 1'b0;
`ifdef LUT_TABLE_LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            done   <= 1'b0;
            wr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state   <= SHIFT;
                        shifter <= {staging[TABLE_BITS-2:0], 1'b0};
                        count   <= '0;
                        sd      <= staging[TABLE_BITS-1];
                        sd_cs_n <= 1'b0;
                        busy    <= 1'b1;
                        wr_err  <= wr_en;
`ifdef LUT_TABLE_LOADER_CHECKSUM_EN
                        // Clear and fold in the top entry, which is already aligned.
                        csum    <= staging[TABLE_BITS-1 -: OUT_WIDTH];
`endif
                    end
                end
                SHIFT: begin
                    wr_err <= wr_en;
                    if (count == LAST_BIT) begin
                        state   <= DONE;
                        sd      <= 1'b0;
                        sd_cs_n <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        count   <= '0;
                    end else begin
                        sd      <= shifter[TABLE_BITS-1];
                        shifter <= {shifter[TABLE_BITS-2:0], 1'b0};
                        count   <= count + 1'b1;
`ifdef LUT_TABLE_LOADER_CHECKSUM_EN
                        // A new entry sits top-aligned after each OUT_WIDTH shifts.
                        if ((int'(count) % OUT_WIDTH) == OUT_WIDTH - 1) begin
                            csum <= csum ^ shifter[TABLE_BITS-1 -: OUT_WIDTH];
                        end
`endif
                    end
                end
                DONE: begin
                    wr_err <= wr_en;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_table_loader.sv
// Self-checking bench for lut_table_loader with a cycle-level behavioural
// model (table array + stream start time) and a downstream LUT register.
module tb_lut_table_loader;

    localparam int IW = 4;
    localparam int OW = 4;
    localparam int NE = 16;
    localparam int TB = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [OW-1:0] wr_data;
    logic          go;
    logic          sd, sd_cs_n, busy, done, wr_err;
`ifdef LUT_TABLE_LOADER_CHECKSUM_EN
    logic [OW-1:0] csum;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lut_table_loader #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .go      (go),
        .sd      (sd),
        .sd_cs_n (sd_cs_n),
        .busy    (busy),
        .done    (done),
        .wr_err  (wr_err)
`ifdef LUT_TABLE_LOADER_CHECKSUM_EN
        ,
        .csum    (csum)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream serial-to-parallel LUT register.
    logic [TB-1:0] ds;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ds <= '0;
        else if (!sd_cs_n) ds <= {ds[TB-2:0], sd};
    end

    // Behavioural model: the table as an array, a stream as a snapshot plus
    // the edge at which it was accepted.
    logic [OW-1:0] tab [NE];
    logic [TB-1:0] snap = '0;
    logic [OW-1:0] snap_x = '0;
    int            edge_n = 0;
    int            t0 = 0;
    int            k;
    bit            active = 0;
    bit            in_use, accept;
    logic          e_sd = 1'b0, e_cs = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [OW-1:0] e_csum = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NE; i++) tab[i] = '0;
            active = 0; edge_n = 0; t0 = 0;
            e_sd = 1'b0; e_cs = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
            e_csum = '0;
        end else begin
            edge_n++;
            k = edge_n - t0;
            in_use = active && (k >= 1) && (k <= TB + 1);
            accept = go && !in_use;
            e_err = wr_en && (in_use || accept);
            if (wr_en && !in_use && !go) tab[wr_addr] = wr_data;
            if (accept) begin
                snap_x = '0;
                for (int i = 0; i < NE; i++) begin
                    for (int b = 0; b < OW; b++) snap[i*OW + b] = tab[i][b];
                    snap_x ^= tab[i];
                end
                active = 1;
                t0 = edge_n;
            end
            k = edge_n - t0;
            e_sd = 1'b0; e_cs = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            if (active) begin
                if (k < TB) begin
                    e_cs = 1'b0; e_busy = 1'b1; e_sd = snap[TB-1-k];
                end else if (k == TB) begin
                    e_done = 1'b1; e_csum = snap_x;
                end else begin
                    active = 0;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("sd_cs_n", sd_cs_n, e_cs);
        chk("sd", sd, e_sd);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("wr_err", wr_err, e_err);
        if (e_done) begin
            chk("downstream_table", ds, snap);
`ifdef LUT_TABLE_LOADER_CHECKSUM_EN
            chk("csum", csum, e_csum);
`endif
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write(input int a, input int d);
        wr_en = 1'b1; wr_addr = IW'(a); wr_data = OW'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Pulse go and count cycles until done (cycle 1 = first after go sampled).
    task automatic go_wait(output int cyc);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    int cyc;

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty table commit.
        go_wait(cyc);
        chk("t1_done_latency", cyc, 65);
        chk("t1_table_zero", ds, 64'h0);
        repeat (2) @(negedge clk);

        // Entry i = i.
        for (int i = 0; i < NE; i++) write(i, i);
        go_wait(cyc);
        chk("t2_first_nibble", ds[63:60], 4'hF);
        chk("t2_last_nibble", ds[3:0], 4'h0);
        chk("t2_sel5", ds[5*OW +: OW], 4'h5);
        chk("t2_sel15", ds[15*OW +: OW], 4'hF);
        chk("t2_table", ds, 64'hFEDCBA9876543210);
        repeat (2) @(negedge clk);

        // Write while busy is rejected; re-commit shows original entry.
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        write(3, 'hA);
        chk("t3_wr_err_pulse", wr_err, 1'b1);
        @(negedge clk);
        chk("t3_wr_err_one_cycle", wr_err, 1'b0);
        repeat (80) @(negedge clk);
        go_wait(cyc);
        chk("t3_entry3", ds[3*OW +: OW], 4'h3);

        // Same-cycle go and write on a zero table.
        do_reset();
        go = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 4'hF;
        @(negedge clk);
        go = 1'b0; wr_en = 1'b0;
        chk("t4_wr_err", wr_err, 1'b1);
        repeat (70) @(negedge clk);
        go_wait(cyc);
        chk("t4_entry0", ds[OW-1:0], 4'h0);

        // Asynchronous reset in the middle of a stream.
        write(7, 'h9);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (19) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cs_async", sd_cs_n, 1'b1);
        chk("t5_busy_async", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        go_wait(cyc);
        chk("t5_table_zero", ds, 64'h0);
        repeat (2) @(negedge clk);

`ifdef LUT_TABLE_LOADER_CHECKSUM_EN
        write(0, 'h1); write(1, 'h2); write(2, 'h4); write(3, 'h8);
        go_wait(cyc);
        chk("csum_literal", csum, 4'hF);
        repeat (2) @(negedge clk);
`endif

        // Randomized writes and commits against the model.
        for (int n = 0; n < 3000; n++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = IW'($urandom);
            wr_data = OW'($urandom);
            go      = ($urandom_range(0, 24) == 0);
            @(negedge clk);
        end
        wr_en = 1'b0; go = 1'b0;
        repeat (80) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
